// File: rtl/axis_byte_packer.sv
// axis_byte_packer: packs a byte-wide AXI-Stream into BYTES-wide little-endian words.
// A completing byte (last lane or tlast) loads the output register directly; partial
// words are padded with PAD_BYTE. The output register holds its word until accepted.
// BYTES must be at least 2 (the accumulator holds BYTES-1 lanes).
module axis_byte_packer #(
  parameter int unsigned BYTES    = 5,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [7:0]         s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  output logic [BYTES*8-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  input  logic               m_axis_tready,
  output logic [31:0]        word_count
);

  localparam int unsigned W        = BYTES * 8;
  localparam int unsigned AccW     = (BYTES - 1) * 8;
  localparam int unsigned IdxW     = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(BYTES - 1);

  // Registered state
  logic [IdxW-1:0] r_idx;
  logic [AccW-1:0] r_acc;
  logic [W-1:0]    r_tdata;
  logic            r_tvalid;
  logic            r_tlast;
  logic [31:0]     r_word_count;

  // Combinational helpers
  logic            w_ready;
  logic            w_in_beat;
  logic            w_out_beat;
  logic            w_complete;
  logic            w_load;
  logic [W-1:0]    w_acc_ext;
  logic [W-1:0]    w_word;
  logic [AccW-1:0] w_acc_next;

  // Handshake decode; ready depends only on the output register and the sink.
  always_comb begin
    w_ready    = !r_tvalid || m_axis_tready;
    w_in_beat  = s_axis_tvalid && w_ready;
    w_out_beat = r_tvalid && m_axis_tready;
    w_complete = (r_idx == IdxLast) || s_axis_tlast;
    w_load     = w_in_beat && w_complete;
  end

  // Assemble the outgoing word: stored lanes below idx, live byte at idx, pad above.
  always_comb begin
    // Extend acc by one pad lane so every lane index is in range for the loop.
    w_acc_ext = {PAD_BYTE, r_acc};
    w_word    = {BYTES{PAD_BYTE}};
    for (int unsigned l = 0; l < BYTES; l++) begin
      if (l < 32'(r_idx)) begin
        w_word[8*l +: 8] = w_acc_ext[8*l +: 8];
      end else if (l == 32'(r_idx)) begin
        w_word[8*l +: 8] = s_axis_tdata;
      end
    end
  end

  // Next accumulator value for a non-completing byte: write lane idx only.
  always_comb begin
    w_acc_next = r_acc;
    for (int unsigned l = 0; l < BYTES - 1; l++) begin
      if (l == 32'(r_idx)) begin
        w_acc_next[8*l +: 8] = s_axis_tdata;
      end
    end
  end

  // Byte index and accumulator; cleared to pad after every completed word.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_idx <= '0;
      r_acc <= {(BYTES - 1){PAD_BYTE}};
    end else if (w_in_beat) begin
      if (w_complete) begin
        r_idx <= '0;
        r_acc <= {(BYTES - 1){PAD_BYTE}};
      end else begin
        r_idx <= r_idx + IdxW'(1);
        r_acc <= w_acc_next;
      end
    end
  end

  // Output register; a load in the same cycle as a drain keeps tvalid high.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
    end else if (w_load) begin
      r_tdata  <= w_word;
      r_tvalid <= 1'b1;
      r_tlast  <= s_axis_tlast;
    end else if (w_out_beat) begin
      r_tvalid <= 1'b0;
    end
  end

  // Free-running count of accepted output words; only reset clears it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_word_count <= '0;
    end else if (w_out_beat) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

  assign s_axis_tready = w_ready;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign word_count    = r_word_count;

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed bench for axis_byte_packer with a scoreboard of expected output words.
module tb_axis_byte_packer;

  localparam int unsigned BYTES    = 5;
  localparam logic [7:0]  PAD_BYTE = 8'h00;

  logic               ap_clk = 1'b0;
  logic               ap_rst = 1'b1;
  logic [7:0]         s_axis_tdata = '0;
  logic               s_axis_tvalid = 1'b0;
  logic               s_axis_tlast = 1'b0;
  logic               s_axis_tready;
  logic [BYTES*8-1:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic               m_axis_tready = 1'b1;
  logic [31:0]        word_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [BYTES*8:0] exp_q[$];   // {tlast, tdata}
  logic [7:0]       m_bytes[$]; // bytes of the partial word in the model
  int               beat_q[$];  // cycle numbers of output beats

  axis_byte_packer #(
    .BYTES   (BYTES),
    .PAD_BYTE(PAD_BYTE)
  ) dut (
    .ap_clk       (ap_clk),
    .ap_rst       (ap_rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .word_count   (word_count)
  );

  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: collect bytes, emit a padded word on tlast or when full.
  task automatic model_byte(input logic [7:0] b, input logic last);
    logic [BYTES*8-1:0] w;
    m_bytes.push_back(b);
    if (last || m_bytes.size() == BYTES) begin
      w = {BYTES{PAD_BYTE}};
      for (int i = 0; i < m_bytes.size(); i++) w[8*i +: 8] = m_bytes[i];
      exp_q.push_back({last, w});
      m_bytes.delete();
    end
  endtask

  // Drive one byte until accepted (bounded), then update the model.
  task automatic send_byte(input logic [7:0] b, input logic last);
    logic acc;
    int   n;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge ap_clk);
      acc = s_axis_tready;
      @(posedge ap_clk);
      #1;
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (acc) model_byte(b, last);
    else check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic do_reset(input int ncyc);
    ap_rst        = 1'b1;
    s_axis_tvalid = 1'b0;
    repeat (ncyc) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    exp_q.delete();
    m_bytes.delete();
  endtask

  task automatic idle(input int ncyc);
    repeat (ncyc) @(posedge ap_clk);
    #1;
  endtask

  // Output monitor: an output beat will occur at the coming rising edge.
  always @(negedge ap_clk) begin
    logic [BYTES*8:0] e;
    if (!ap_rst && m_axis_tvalid && m_axis_tready) begin
      beat_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_word", 64'(m_axis_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_tdata", 64'(m_axis_tdata), 64'(e[BYTES*8-1:0]));
        check("sb_tlast", 64'(m_axis_tlast), 64'(e[BYTES*8]));
      end
    end
  end

  initial begin
    // Reset state
    do_reset(2);
    check("rst_s_tready", 64'(s_axis_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);

    // Basic pack
    m_axis_tready = 1'b1;
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h9A, 1'b1);
    check("basic_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("basic_tdata", 64'(m_axis_tdata), 64'h9A12345678);
    check("basic_tlast", 64'(m_axis_tlast), 64'd1);
    idle(1);
    check("basic_word_count", 64'(word_count), 64'd1);
    check("basic_drained", 64'(m_axis_tvalid), 64'd0);

    // Partial flush
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    check("partial_tdata", 64'(m_axis_tdata), 64'h0000002211);
    check("partial_tlast", 64'(m_axis_tlast), 64'd1);
    idle(1);
    check("partial_word_count", 64'(word_count), 64'd2);

    // Backpressure, then release with a simultaneous single-byte load
    m_axis_tready = 1'b0;
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_byte(8'hA5, 1'b1);
    s_axis_tdata  = 8'hB1;
    s_axis_tlast  = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      check("bp_s_tready", 64'(s_axis_tready), 64'd0);
      check("bp_tdata_hold", 64'(m_axis_tdata), 64'hA5A4A3A2A1);
      check("bp_tvalid_hold", 64'(m_axis_tvalid), 64'd1);
    end
    check("bp_word_count", 64'(word_count), 64'd2);
    m_axis_tready = 1'b1;
    #1;
    check("release_s_tready", 64'(s_axis_tready), 64'd1);
    model_byte(8'hB1, 1'b1);
    @(posedge ap_clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("sim_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("sim_tdata", 64'(m_axis_tdata), 64'h00000000B1);
    check("sim_tlast", 64'(m_axis_tlast), 64'd1);
    check("sim_word_count_a", 64'(word_count), 64'd3);
    idle(1);
    check("sim_word_count_b", 64'(word_count), 64'd4);

    // Streaming two words back-to-back
    beat_q.delete();
    for (int i = 0; i < 10; i++) send_byte(8'(i), i == 9);
    idle(1);
    check("stream_word_count", 64'(word_count), 64'd6);
    check("stream_beats", 64'(beat_q.size()), 64'd2);
    if (beat_q.size() == 2) check("stream_spacing", 64'(beat_q[1] - beat_q[0]), 64'd5);

    // Reset with a held word discards it
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'hC1 + 8'(i), i == 4);
    check("held_tvalid", 64'(m_axis_tvalid), 64'd1);
    do_reset(1);
    check("held_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("held_rst_wc", 64'(word_count), 64'd0);
    m_axis_tready = 1'b1;
    idle(2);
    check("held_rst_no_emit", 64'(word_count), 64'd0);

    // Reset mid-word
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    do_reset(1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5);
    check("midrst_tdata", 64'(m_axis_tdata), 64'h0504030201);
    idle(2);
    check("midrst_word_count", 64'(word_count), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
